// File: rtl/mem_byte_port_if.sv
// Request/response handshake bundle between the CPU load/store unit and mem_byte_port.
interface mem_byte_port_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_byte_port.sv
// Byte/half/word load-store front-end for a byte-write, word-read RAM port.
// Optional misalignment trap: define MEM_BYTE_PORT_ALIGN_CHECK_EN.
module mem_byte_port #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_byte_port_if.slave        bus,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {IDLE, STORE, LOAD_ADDR, LOAD_CAP, RESP} state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [1:0]            size_q, size_n;
    logic                  signed_q, signed_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [1:0]            k_q, k_n;

    logic                  req_ready_q, req_ready_n;
    logic                  resp_valid_q, resp_valid_n;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_n;
    logic                  resp_err_q, resp_err_n;
    logic                  mem_we_q, mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_n;

    logic [1:0]            k_inc_c;
    logic [1:0]            last_k_c;
    logic                  misaligned_c;
    logic [DATA_WIDTH-1:0] load_ext_c;

    assign k_inc_c  = k_q + 2'd1;
    assign last_k_c = size_q[1] ? 2'd3 : {1'b0, size_q[0]};

`ifdef MEM_BYTE_PORT_ALIGN_CHECK_EN
    assign misaligned_c = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                          (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign misaligned_c = 1'b0;
`endif

    // Extract and extend the loaded field from the RAM word.
    always_comb begin
        case (size_q)
            2'b00:   load_ext_c = {{(DATA_WIDTH-8){signed_q & mem_dout[7]}}, mem_dout[7:0]};
            2'b01:   load_ext_c = {{(DATA_WIDTH-16){signed_q & mem_dout[15]}}, mem_dout[15:0]};
            default: load_ext_c = mem_dout;
        endcase
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n      = state_q;
        addr_n       = addr_q;
        size_n       = size_q;
        signed_n     = signed_q;
        wdata_n      = wdata_q;
        k_n          = k_q;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata_q;
        resp_err_n   = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = '0;
        mem_din_n    = '0;

        case (state_q)
            IDLE: begin
                req_ready_n = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_n = 1'b0;
                    addr_n      = bus.req_addr;
                    size_n      = bus.req_size;
                    signed_n    = bus.req_signed;
                    wdata_n     = bus.req_wdata;
                    k_n         = 2'd0;
                    if (misaligned_c) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end else if (bus.req_we) begin
                        state_n    = STORE;
                        mem_we_n   = 1'b1;
                        mem_addr_n = bus.req_addr;
                        mem_din_n  = DATA_WIDTH'(bus.req_wdata[7:0]);
                    end else begin
                        state_n    = LOAD_ADDR;
                        mem_addr_n = bus.req_addr;
                    end
                end
            end
            STORE: begin
                if (k_q == last_k_c) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = '0;
                end else begin
                    k_n        = k_inc_c;
                    mem_we_n   = 1'b1;
                    mem_addr_n = addr_q + ADDR_WIDTH'(k_inc_c);
                    mem_din_n  = DATA_WIDTH'(wdata_q[{k_inc_c, 3'b000} +: 8]);
                end
            end
            LOAD_ADDR: begin
                state_n    = LOAD_CAP;
                mem_addr_n = addr_q;
            end
            LOAD_CAP: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = load_ext_c;
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            k_q          <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_n;
            addr_q       <= addr_n;
            size_q       <= size_n;
            signed_q     <= signed_n;
            wdata_q      <= wdata_n;
            k_q          <= k_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_err_q   <= resp_err_n;
            mem_we_q     <= mem_we_n;
            mem_addr_q   <= mem_addr_n;
            mem_din_q    <= mem_din_n;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;

endmodule

// File: tb/tb_mem_byte_port.sv
// Self-checking bench for mem_byte_port: directed plan steps plus random traffic vs a byte-array model.
module tb_mem_byte_port;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
`ifdef MEM_BYTE_PORT_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          sgn;
        logic [15:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic          clk;
    logic          rst_n;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          ram_clr;

    mem_byte_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_byte_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // RAM with byte writes and a registered read address
    logic [7:0]  ram [0:65535];
    logic [15:0] raddr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din[7:0];
        end
        raddr <= mem_addr;
    end
    assign mem_dout = {ram[raddr + 16'd3], ram[raddr + 16'd2], ram[raddr + 16'd1], ram[raddr]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int          vectors;
    int          miscompares;
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input req_t r);
        if (!ALIGN_CHK) return 1'b0;
        if (r.size == 2'b01) return r.addr % 2 != 0;
        if (r.size >= 2'b10) return r.addr % 4 != 0;
        return 1'b0;
    endfunction

    // Load result computed arithmetically from the byte model
    function automatic logic [31:0] model_load(input req_t r);
        longint v;
        int     n;
        v = 0;
        n = nbytes(r.size);
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[16'(r.addr + 16'(i))]) << (8 * i));
        if (r.sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic present(input req_t r);
        bus.req_we     = r.we;
        bus.req_size   = r.size;
        bus.req_signed = r.sgn;
        bus.req_addr   = r.addr;
        bus.req_wdata  = r.wdata;
        bus.req_valid  = 1'b1;
    endtask

    // Caller has r presented in an idle cycle; checks the whole transaction cycle by cycle
    task automatic run_txn(input req_t r, input bit hold, input req_t nxt);
        int          n;
        logic [31:0] exp;
        n = nbytes(r.size);
        chk("ready_at_accept", 32'(bus.req_ready), 32'd1);
        step();
        if (hold) present(nxt);
        else bus.req_valid = 1'b0;
        if (is_mis(r)) begin
            chk("mis_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("mis_resp_err", 32'(bus.resp_err), 32'd1);
            chk("mis_rdata", bus.resp_rdata, 32'd0);
            chk("mis_no_we", 32'(mem_we), 32'd0);
            last_rdata = 32'd0;
        end else if (r.we) begin
            for (int i = 0; i < n; i++) begin
                chk("st_we", 32'(mem_we), 32'd1);
                chk("st_addr", 32'(mem_addr), 32'(16'(r.addr + 16'(i))));
                chk("st_din", mem_din, (r.wdata >> (8 * i)) & 32'hFF);
                chk("st_busy_ready", 32'(bus.req_ready), 32'd0);
                chk("st_no_resp", 32'(bus.resp_valid), 32'd0);
                ref_mem[16'(r.addr + 16'(i))] = 8'((r.wdata >> (8 * i)) & 32'hFF);
                step();
            end
            chk("st_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("st_resp_rdata", bus.resp_rdata, 32'd0);
            chk("st_resp_err", 32'(bus.resp_err), 32'd0);
            chk("st_resp_we", 32'(mem_we), 32'd0);
            chk("st_resp_addr", 32'(mem_addr), 32'd0);
            last_rdata = 32'd0;
        end else begin
            chk("ld_addr", 32'(mem_addr), 32'(r.addr));
            chk("ld_we", 32'(mem_we), 32'd0);
            chk("ld_no_resp1", 32'(bus.resp_valid), 32'd0);
            step();
            chk("ld_no_resp2", 32'(bus.resp_valid), 32'd0);
            chk("ld_busy_ready", 32'(bus.req_ready), 32'd0);
            step();
            exp = model_load(r);
            chk("ld_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("ld_rdata", bus.resp_rdata, exp);
            chk("ld_resp_err", 32'(bus.resp_err), 32'd0);
            last_rdata = exp;
        end
        chk("resp_ready_low", 32'(bus.req_ready), 32'd0);
        step();
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("idle_rdata_hold", bus.resp_rdata, last_rdata);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'd0);
    endtask

    task automatic go(input bit we, input logic [1:0] size, input bit sgn,
                      input logic [15:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
        present(r);
        run_txn(r, 1'b0, r);
    endtask

    req_t ra, rb, r0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_rdata  = 32'd0;
        rst_n       = 1'b0;
        ram_clr     = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", mem_din, 32'd0);

        // Word store presented so that it is accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        r0.we = 1'b1; r0.size = 2'b10; r0.sgn = 1'b0; r0.addr = 16'h0010; r0.wdata = 32'hDEADBEEF;
        present(r0);
        run_txn(r0, 1'b0, r0);
        go(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
        chk("word_readback", bus.resp_rdata, 32'hDEADBEEF);

        go(1'b1, 2'b00, 1'b0, 16'h0020, 32'h00000080);
        go(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0);
        chk("byte_signed", bus.resp_rdata, 32'hFFFFFF80);
        go(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0);
        chk("byte_unsigned", bus.resp_rdata, 32'h00000080);

        go(1'b1, 2'b01, 1'b0, 16'h0030, 32'h00008001);
        go(1'b0, 2'b01, 1'b1, 16'h0030, 32'h0);
        chk("half_signed", bus.resp_rdata, 32'hFFFF8001);
        go(1'b0, 2'b01, 1'b0, 16'h0030, 32'h0);
        chk("half_unsigned", bus.resp_rdata, 32'h00008001);
        go(1'b1, 2'b00, 1'b0, 16'h0031, 32'h0000007F);
        go(1'b0, 2'b01, 1'b1, 16'h0030, 32'h0);
        chk("half_patched", bus.resp_rdata, 32'h00007F01);

        // req_valid held through a busy word store; the next request waits its turn
        ra.we = 1'b1; ra.size = 2'b10; ra.sgn = 1'b0; ra.addr = 16'h0060; ra.wdata = 32'hCAFEF00D;
        rb.we = 1'b1; rb.size = 2'b01; rb.sgn = 1'b0; rb.addr = 16'h0064; rb.wdata = 32'h12345566;
        present(ra);
        run_txn(ra, 1'b1, rb);
        run_txn(rb, 1'b0, rb);
        step();
        chk("no_dup_we", 32'(mem_we), 32'd0);
        go(1'b0, 2'b10, 1'b0, 16'h0060, 32'h0);
        chk("held_a_data", bus.resp_rdata, 32'hCAFEF00D);
        go(1'b0, 2'b01, 1'b0, 16'h0064, 32'h0);
        chk("held_b_data", bus.resp_rdata, 32'h00005566);

        // Reset pulse in the middle of a word store
        r0.we = 1'b1; r0.size = 2'b10; r0.sgn = 1'b0; r0.addr = 16'h0040; r0.wdata = 32'h11223344;
        present(r0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        chk("rst_mid_we1", 32'(mem_we), 32'd1);
        ref_mem[16'h0040] = 8'h44;
        step();
        chk("rst_mid_we2", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_drop", 32'(mem_we), 32'd0);
        chk("rst_mid_ready_hi", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("rst_mid_no_we", 32'(mem_we), 32'd0);
            chk("rst_mid_idle", 32'(bus.req_ready), 32'd1);
        end
        go(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0);
        chk("rst_mid_partial", bus.resp_rdata, 32'h00000044);

        // Word store to an odd address
        go(1'b1, 2'b10, 1'b0, 16'h0013, 32'h0A0B0C0D);
        go(1'b0, 2'b00, 1'b0, 16'h0016, 32'h0);
        chk("odd_store_top", bus.resp_rdata, ALIGN_CHK ? 32'h00000000 : 32'h0000000A);

        // Random traffic in a small window so loads see earlier stores
        for (int t = 0; t < 60; t++) begin
            go(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               16'(16'h0100 + 16'($urandom_range(0, 47))), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
